priority_encoder_8to3: RTL and testbench
========================================

PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop synchronizer stages on req_n; legal range 1..3.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_n  input  8  request lines, active-low; bit 7 highest priority, bit 0 lowest.
REQ-005 ei_n  input  1  enable input, active-low; high disables capture and flushes pending requests.
REQ-006 ack  input  1  consumer accepts the presented code; active-high, single-cycle pulse.
REQ-007 code  output  3  index of the presented request, binary (not inverted).
REQ-008 gs_n  output  1  group-select / valid, active-low; low while code is valid.
REQ-009 eo_n  output  1  enable output, active-low; low when enabled, idle and no request pending.
REQ-010 fev, fodd  output  1 each  parity of code, present only under PARITY_OUT_EN (see Configuration).

Function
REQ-011 req_n shall pass through SYNC_STAGES synchronizer flops; only the synchronized value req_s is used internally.
REQ-012 State machine states: IDLE, PRESENT; reset state IDLE.
REQ-013 IDLE: if ei_n=0 and ~req_s!=0, load pending<=~req_s, code<=highest set index, gs_n<=0, go PRESENT.
REQ-014 Latency: req_n falling edge to gs_n low = SYNC_STAGES+1 clock cycles.
REQ-015 PRESENT: code and gs_n shall hold stable until ack=1; newly asserted requests are ORed into pending each cycle without changing code.
REQ-016 PRESENT with ack=1: clear pending[code]; if remaining pending (including same-cycle new requests) nonzero, next cycle code=highest remaining index, gs_n stays 0; else gs_n<=1, go IDLE.
REQ-017 A request bit still held low after being served shall be re-captured only after it returns to IDLE and is resampled; it is not re-ORed in the ack cycle.
REQ-018 ack while gs_n=1 shall be ignored.
REQ-019 ei_n=1 in any state: next cycle pending<=0, gs_n<=1, code<=0, state IDLE; takes priority over ack.
REQ-020 eo_n registered: eo_n=0 iff ei_n=0, state IDLE, and ~req_s==0; otherwise 1.
REQ-021 All outputs registered; no combinational path from any input to any output.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, pending=0, synchronizers=all ones, code=0, gs_n=1, eo_n=1, fev=1, fodd=0.
REQ-023 Reset mid-PRESENT shall drop the presented code and all pending requests; no ack required afterwards.
REQ-024 Reset release shall be synchronous to clk externally; the block adds no release synchronizer.

Configuration
REQ-025 Macro PRIORITY_ENCODER_PARITY_OUT_EN defined: fev/fodd ports exist, registered alongside code; fodd=1 when code has an odd number of ones (1,2,4,7), fev=~fodd.
REQ-026 Macro undefined: fev/fodd ports and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package priority_encoder_pkg: state enum (IDLE, PRESENT), IDX_W=3, N_REQ=8.
REQ-028 One sub-module prio_find8: combinational, 8-bit mask in -> 3-bit highest index plus any flag; instantiated once.

Verification
REQ-029 Reset then ei_n=0, req_n=8'hFF -> gs_n=1, eo_n=0 after SYNC_STAGES+1 cycles, code=0.
REQ-030 req_n=8'b1101_0111 held (bits 5,3 requested), SYNC_STAGES=2 -> gs_n low at cycle 3, code=5; ack -> code=3; ack -> gs_n=1 next cycle.
REQ-031 Present code=2, no ack for 10 cycles while bit 6 newly requested -> code stays 2; ack -> code=6.
REQ-032 PRESENT with pending {4,1}, ei_n=1 pulsed with simultaneous ack -> next cycle gs_n=1, code=0, state IDLE, no further codes.
REQ-033 rst_n asserted mid-PRESENT (code=7) -> gs_n=1, code=0 immediately without a clock edge; after release and idle inputs, gs_n remains 1.
REQ-034 With PRIORITY_ENCODER_PARITY_OUT_EN: sweep single requests 0..7 -> fodd=1 exactly for codes 1,2,4,7, fev complementary; without the macro, build contains no fev/fodd ports.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared types and sizes for the 8-to-3 registered priority encoder.
package priority_encoder_pkg;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_REQ = 8;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;
endpackage

// File: rtl/priority_encoder_if.sv
// Request/code bus of the priority encoder; fev/fodd exist only with PRIORITY_ENCODER_PARITY_OUT_EN.
interface priority_encoder_if;
  import priority_encoder_pkg::*;

  logic [N_REQ-1:0] req_n;
  logic             ei_n;
  logic             ack;
  logic [IDX_W-1:0] code;
  logic             gs_n;
  logic             eo_n;
`ifdef PRIORITY_ENCODER_PARITY_OUT_EN
  logic             fev;
  logic             fodd;

  modport master (output req_n, ei_n, ack, input code, gs_n, eo_n, fev, fodd);
  modport slave  (input req_n, ei_n, ack, output code, gs_n, eo_n, fev, fodd);
`else
  modport master (output req_n, ei_n, ack, input code, gs_n, eo_n);
  modport slave  (input req_n, ei_n, ack, output code, gs_n, eo_n);
`endif
endinterface

// File: rtl/prio_find8.sv
// Combinational search: index of the highest set bit of an 8-bit mask, plus an any-set flag.
module prio_find8
  import priority_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last hit, i.e. the highest set bit, wins.
  always_comb begin
    idx = '0;
    any = |mask;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with synchronized active-low requests and ack handshake.
// Optional parity outputs fev/fodd under macro PRIORITY_ENCODER_PARITY_OUT_EN.
module priority_encoder_8to3
  import priority_encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  priority_encoder_if.slave bus
);

  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q, sync_d;
  logic [N_REQ-1:0] req_act, act_prev_q, act_prev_d, new_req;
  logic [N_REQ-1:0] pending_q, pending_d, clr, remain, find_mask;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] code_q, code_d, find_idx;
  logic             gs_n_q, gs_n_d, eo_n_q, eo_n_d, find_any;

  assign req_act = ~sync_q[SYNC_STAGES-1];
  // Only fresh assertions join pending while presenting; a served line held low waits for IDLE.
  assign new_req = req_act & ~act_prev_q;
  assign clr     = N_REQ'(1) << code_q;
  assign remain  = (pending_q & ~clr) | new_req;
  assign find_mask = (state_q == IDLE) ? req_act : remain;

  prio_find8 u_find (
    .mask (find_mask),
    .idx  (find_idx),
    .any  (find_any)
  );

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.req_n;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    if (bus.ei_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (find_any) state_d = PRESENT;
        PRESENT: if (bus.ack && !find_any) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pending_d  = pending_q;
    code_d     = code_q;
    gs_n_d     = gs_n_q;
    act_prev_d = req_act;
    eo_n_d     = ~(~bus.ei_n & (state_q == IDLE) & ~|req_act);
    if (bus.ei_n) begin
      pending_d = '0;
      code_d    = '0;
      gs_n_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (find_any) begin
            pending_d = req_act;
            code_d    = find_idx;
            gs_n_d    = 1'b0;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            pending_d = remain;
            if (find_any) begin
              code_d = find_idx;
            end else begin
              code_d = '0;
              gs_n_d = 1'b1;
            end
          end else begin
            pending_d = pending_q | new_req;
          end
        end
        default: begin
          pending_d = '0;
          code_d    = '0;
          gs_n_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      act_prev_q <= '0;
      pending_q  <= '0;
      state_q    <= IDLE;
      code_q     <= '0;
      gs_n_q     <= 1'b1;
      eo_n_q     <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      act_prev_q <= act_prev_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      code_q     <= code_d;
      gs_n_q     <= gs_n_d;
      eo_n_q     <= eo_n_d;
    end
  end

  assign bus.code = code_q;
  assign bus.gs_n = gs_n_q;
  assign bus.eo_n = eo_n_q;

`ifdef PRIORITY_ENCODER_PARITY_OUT_EN
  logic fodd_q, fodd_d;

  always_comb fodd_d = ^code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fodd_q <= 1'b0;
    else        fodd_q <= fodd_d;
  end

  assign bus.fodd = fodd_q;
  assign bus.fev  = ~fodd_q;
`endif

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: directed scenarios plus randomized traffic vs a behavioural model.
module tb_priority_encoder_8to3;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  priority_encoder_if bus ();

  priority_encoder_8to3 #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: request history queue, pending set, presented code.
  logic [7:0] m_q[$];
  logic [7:0] m_pend, m_prev_act;
  bit         m_present;
  int         m_code, m_gs, m_eo;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    m_q = {};
    repeat (S) m_q.push_back(8'hFF);
    m_pend = '0; m_prev_act = '0; m_present = 0;
    m_code = 0; m_gs = 1; m_eo = 1;
  endtask

  task automatic m_step();
    logic [7:0] rs, act, nw;
    rs = m_q.pop_front();
    m_q.push_back(bus.req_n);
    act = ~rs;
    nw = act & ~m_prev_act;
    m_prev_act = act;
    m_eo = (bus.ei_n == 1'b0 && !m_present && act == 8'h00) ? 0 : 1;
    if (bus.ei_n) begin
      m_pend = '0; m_present = 0; m_code = 0; m_gs = 1;
    end else if (!m_present) begin
      if (act != 8'h00) begin
        m_pend = act; m_code = highest(act); m_gs = 0; m_present = 1;
      end
    end else if (bus.ack) begin
      m_pend[m_code] = 1'b0;
      m_pend = m_pend | nw;
      if (m_pend != 8'h00) m_code = highest(m_pend);
      else begin m_code = 0; m_gs = 1; m_present = 0; end
    end else begin
      m_pend = m_pend | nw;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    if (rst_n) begin
      chk("model_code", bus.code, m_code);
      chk("model_gs_n", bus.gs_n, m_gs);
      chk("model_eo_n", bus.eo_n, m_eo);
`ifdef PRIORITY_ENCODER_PARITY_OUT_EN
      chk("model_fodd", bus.fodd, $countones(m_code) & 1);
      chk("model_fev", bus.fev, 1 - ($countones(m_code) & 1));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    bus.ei_n = 1'b1; bus.req_n = 8'hFF; bus.ack = 1'b0;
    cyc(S + 2);
    bus.ei_n = 1'b0;
    cyc(1);
  endtask

  initial begin
    bus.req_n = 8'hFF; bus.ei_n = 1'b1; bus.ack = 1'b0;
    m_reset();
    cyc(2);
    chk("rst_code", bus.code, 0);
    chk("rst_gs_n", bus.gs_n, 1);
    chk("rst_eo_n", bus.eo_n, 1);
    rst_n = 1'b1; bus.ei_n = 1'b0;
    cyc(S + 1);
    chk("idle_gs_n", bus.gs_n, 1);
    chk("idle_eo_n", bus.eo_n, 0);
    chk("idle_code", bus.code, 0);

    // Bits 5 and 3 held low.
    bus.req_n = 8'hD7;
    cyc(S);
    chk("lat_early_gs_n", bus.gs_n, 1);
    cyc(1);
    chk("lat_gs_n", bus.gs_n, 0);
    chk("first_code", bus.code, 5);
    bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
    chk("second_code", bus.code, 3);
    chk("second_gs_n", bus.gs_n, 0);
    bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
    chk("served_gs_n", bus.gs_n, 1);
    chk("served_code", bus.code, 0);
    cyc(1);
    chk("recapture_gs_n", bus.gs_n, 0);
    chk("recapture_code", bus.code, 5);
    flush();

    // Code 2 held without ack while bit 6 arrives.
    bus.req_n = 8'hFB;
    cyc(S + 1);
    chk("hold_code_init", bus.code, 2);
    bus.req_n = 8'hBB;
    cyc(10);
    chk("hold_code", bus.code, 2);
    bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
    chk("late_code", bus.code, 6);
    chk("late_gs_n", bus.gs_n, 0);
    flush();

    // Pending {4,1}, ei_n pulse together with ack.
    bus.req_n = 8'hED;
    cyc(S + 1);
    chk("pend_code", bus.code, 4);
    bus.req_n = 8'hFF;
    cyc(S + 1);
    chk("pend_code_held", bus.code, 4);
    bus.ei_n = 1'b1; bus.ack = 1'b1; cyc(1); bus.ei_n = 1'b0; bus.ack = 1'b0;
    chk("dis_gs_n", bus.gs_n, 1);
    chk("dis_code", bus.code, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("dis_no_more_gs_n", bus.gs_n, 1);
    end

    // Asynchronous reset while presenting code 7.
    bus.req_n = 8'h7F;
    cyc(S + 1);
    chk("pre_rst_code", bus.code, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gs_n", bus.gs_n, 1);
    chk("async_rst_code", bus.code, 0);
    bus.req_n = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("post_rst_gs_n", bus.gs_n, 1);

`ifdef PRIORITY_ENCODER_PARITY_OUT_EN
    begin
      logic [7:0] odd_tbl;
      odd_tbl = 8'b1001_0110;
      for (int i = 0; i < 8; i++) begin
        flush();
        bus.req_n = ~(8'h01 << i);
        cyc(S + 1);
        chk("sweep_code", bus.code, i);
        chk("sweep_fodd", bus.fodd, odd_tbl[i]);
        chk("sweep_fev", bus.fev, !odd_tbl[i]);
      end
    end
`endif

    // Randomized traffic, checked every cycle by the model.
    flush();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req_n = 8'($urandom | $urandom);
      bus.ack  = ($urandom_range(0, 2) == 0);
      bus.ei_n = ($urandom_range(0, 39) == 0);
      cyc(1);
    end
    bus.ack = 1'b0; bus.ei_n = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
